// File: rtl/stream_mux_pkg.sv
// Shared constants and helpers for the round-robin stream multiplexer.
package stream_mux_pkg;

  localparam int unsigned MODE_FIXED = 0;
  localparam int unsigned MODE_RR    = 1;

  // Ceiling log2. The minimum legal channel count is 2, so the result is always at least 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational grant selection: fixed priority, or round-robin starting at i_ptr,
// with a forced-channel override.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int unsigned CH   = 4,
  parameter int unsigned MODE = MODE_RR,
  localparam int unsigned SELW = clog2(CH)
) (
  input  logic [CH-1:0]   i_valid,
  input  logic [SELW-1:0] i_ptr,
  input  logic            i_force_en,
  input  logic [SELW-1:0] i_force_sel,
  output logic [CH-1:0]   o_grant,
  output logic [SELW-1:0] o_idx,
  output logic            o_any
);

  logic [CH-1:0] w_upper;
  logic [CH-1:0] w_pool;

  // Requests at or above the pointer go first; if none exist, wrap to the full set.
  always_comb begin
    w_upper = '0;
    for (int unsigned i = 0; i < CH; i++) begin
      w_upper[i] = i_valid[i] && (SELW'(i) >= i_ptr);
    end
    if (MODE == MODE_FIXED) begin
      w_pool = i_valid;
    end else begin
      w_pool = (|w_upper) ? w_upper : i_valid;
    end
  end

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    if (i_force_en) begin
      // Out-of-range force_sel never matches any channel, so it yields no grant.
      for (int unsigned i = 0; i < CH; i++) begin
        if (i_force_sel == SELW'(i) && i_valid[i]) begin
          o_grant[i] = 1'b1;
          o_idx      = SELW'(i);
          o_any      = 1'b1;
        end
      end
    end else begin
      for (int unsigned i = 0; i < CH; i++) begin
        if (!o_any && w_pool[i]) begin
          o_grant[i] = 1'b1;
          o_idx      = SELW'(i);
          o_any      = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// CH-to-1 stream multiplexer with a registered output stage and round-robin pointer.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int unsigned N    = 8,
  parameter int unsigned CH   = 4,
  parameter int unsigned MODE = MODE_RR,
  localparam int unsigned SELW = clog2(CH)
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [CH*N-1:0] i_in_data,
  input  logic [CH-1:0]   i_in_valid,
  output logic [CH-1:0]   o_in_ready,
  input  logic            i_force_en,
  input  logic [SELW-1:0] i_force_sel,
  output logic [N-1:0]    o_out_data,
  output logic [SELW-1:0] o_out_sel,
  output logic            o_out_valid,
  input  logic            i_out_ready
);

  logic            w_load_en;
  logic [CH-1:0]   w_grant;
  logic [SELW-1:0] w_idx;
  logic            w_any;
  logic [N-1:0]    w_data;
  logic [SELW-1:0] w_ptr_nxt;

  logic [N-1:0]    r_data;
  logic [SELW-1:0] r_sel;
  logic [SELW-1:0] r_ptr;
  logic            r_valid;

  assign w_load_en = !r_valid || i_out_ready;
  // Gated by reset so no handshake can be signalled while the block is held in reset.
  assign o_in_ready = (i_rst_n && w_load_en) ? w_grant : '0;

  rr_arbiter #(
    .CH   (CH),
    .MODE (MODE)
  ) u_arb (
    .i_valid     (i_in_valid),
    .i_ptr       (r_ptr),
    .i_force_en  (i_force_en),
    .i_force_sel (i_force_sel),
    .o_grant     (w_grant),
    .o_idx       (w_idx),
    .o_any       (w_any)
  );

  always_comb begin
    w_data = '0;
    for (int unsigned i = 0; i < CH; i++) begin
      if (w_grant[i]) begin
        w_data = i_in_data[i*N +: N];
      end
    end
  end

  always_comb begin
    w_ptr_nxt = w_idx + SELW'(1);
    if (w_idx == SELW'(CH - 1)) begin
      w_ptr_nxt = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data  <= '0;
      r_sel   <= '0;
      r_ptr   <= '0;
      r_valid <= 1'b0;
    end else if (w_load_en) begin
      if (w_any) begin
        r_data  <= w_data;
        r_sel   <= w_idx;
        r_valid <= 1'b1;
        if (MODE == MODE_RR && !i_force_en) begin
          r_ptr <= w_ptr_nxt;
        end
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_out_data  = r_data;
  assign o_out_sel   = r_sel;
  assign o_out_valid = r_valid;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Scoreboard bench for stream_mux_rr: round-robin main instance plus fixed-priority
// and three-channel instances for the mode and non-power-of-two cases.
module tb_stream_mux_rr;

  logic clk;
  logic rst_n;

  // Main instance: N=8, CH=4, round-robin.
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic        force_en;
  logic [1:0]  force_sel;
  logic [7:0]  out_data;
  logic [1:0]  out_sel;
  logic        out_valid;
  logic        out_ready;

  // Fixed-priority instance.
  logic [31:0] fp_in_data;
  logic [3:0]  fp_in_valid;
  logic [3:0]  fp_in_ready;
  logic [7:0]  fp_out_data;
  logic [1:0]  fp_out_sel;
  logic        fp_out_valid;

  // Three-channel round-robin instance.
  logic [23:0] c3_in_data;
  logic [2:0]  c3_in_valid;
  logic [2:0]  c3_in_ready;
  logic        c3_force_en;
  logic [1:0]  c3_force_sel;
  logic [7:0]  c3_out_data;
  logic [1:0]  c3_out_sel;
  logic        c3_out_valid;

  stream_mux_rr #(.N(8), .CH(4), .MODE(1)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_in_data   (in_data),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_force_en  (force_en),
    .i_force_sel (force_sel),
    .o_out_data  (out_data),
    .o_out_sel   (out_sel),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready)
  );

  stream_mux_rr #(.N(8), .CH(4), .MODE(0)) dut_fp (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_in_data   (fp_in_data),
    .i_in_valid  (fp_in_valid),
    .o_in_ready  (fp_in_ready),
    .i_force_en  (1'b0),
    .i_force_sel (2'd0),
    .o_out_data  (fp_out_data),
    .o_out_sel   (fp_out_sel),
    .o_out_valid (fp_out_valid),
    .i_out_ready (1'b1)
  );

  stream_mux_rr #(.N(8), .CH(3), .MODE(1)) dut_c3 (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_in_data   (c3_in_data),
    .i_in_valid  (c3_in_valid),
    .o_in_ready  (c3_in_ready),
    .i_force_en  (c3_force_en),
    .i_force_sel (c3_force_sel),
    .o_out_data  (c3_out_data),
    .o_out_sel   (c3_out_sel),
    .o_out_valid (c3_out_valid),
    .i_out_ready (1'b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] sel;
  } sb_t;

  sb_t q[$];
  int  m_ptr;
  int  n_checks;
  int  n_errors;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference arbitration for the main instance, evaluated on stable inputs.
  task automatic sb_step();
    int         gi;
    logic       ld;
    logic [3:0] g;
    sb_t        e;
    check_eq("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
    if (q.size() != 0) begin
      check_eq("out_data", {24'd0, out_data}, {24'd0, q[0].data});
      check_eq("out_sel", {30'd0, out_sel}, {30'd0, q[0].sel});
    end
    ld = (q.size() == 0) || out_ready;
    if (q.size() != 0 && out_ready) void'(q.pop_front());
    gi = -1;
    if (force_en) begin
      if (in_valid[force_sel]) gi = int'(force_sel);
    end else begin
      for (int k = 0; k < 4; k++) begin
        int j;
        j = (m_ptr + k) % 4;
        if (gi < 0 && in_valid[j]) gi = j;
      end
    end
    g = (ld && gi >= 0) ? (4'b0001 << gi) : 4'b0000;
    check_eq("in_ready", {28'd0, in_ready}, {28'd0, g});
    if (ld && gi >= 0) begin
      e.data = in_data[gi*8 +: 8];
      e.sel  = 2'(gi);
      q.push_back(e);
      if (!force_en) m_ptr = (gi + 1) % 4;
    end
  endtask

  // Compare at the falling edge, then return just after the next rising edge.
  task automatic tick();
    @(negedge clk);
    sb_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    m_ptr = 0;
    rst_n = 1'b0;
    in_data = 32'h13121110;
    in_valid = 4'b1111;
    force_en = 1'b0;
    force_sel = 2'd0;
    out_ready = 1'b1;
    fp_in_data = 32'hA3A2A1A0;
    fp_in_valid = 4'b0000;
    c3_in_data = 24'hC2C1C0;
    c3_in_valid = 3'b000;
    c3_force_en = 1'b0;
    c3_force_sel = 2'd0;

    #3;
    check_eq("rst_in_ready", {28'd0, in_ready}, 32'd0);
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_out_data", {24'd0, out_data}, 32'd0);
    @(posedge clk);
    #1;
    check_eq("rst_hold_valid", {31'd0, out_valid}, 32'd0);
    rst_n = 1'b1;

    // Full-throughput round robin over all channels.
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("rr_seq_sel", {30'd0, out_sel}, i % 4);
      check_eq("rr_seq_data", {24'd0, out_data}, 32'h10 + (i % 4));
    end

    // Downstream stall: output and in_ready must freeze.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    out_ready = 1'b1;
    tick();
    tick();

    // Pointer wrap: ch2 sets ptr=3, then a lone ch0 wins and ptr moves to 1.
    in_valid = 4'b0100;
    tick();
    in_valid = 4'b0001;
    tick();
    check_eq("wrap_sel0", {30'd0, out_sel}, 32'd0);
    in_valid = 4'b0011;
    tick();
    check_eq("wrap_sel1", {30'd0, out_sel}, 32'd1);

    // Forced grant must leave ptr=2, visible as ch2 winning over ch0 afterwards.
    force_en = 1'b1;
    force_sel = 2'd2;
    in_valid = 4'b0101;
    tick();
    check_eq("force_sel2", {30'd0, out_sel}, 32'd2);
    force_en = 1'b0;
    tick();
    check_eq("force_ptr_kept", {30'd0, out_sel}, 32'd2);
    force_en = 1'b1;
    in_valid = 4'b0001;
    tick();
    tick();
    check_eq("force_nogrant", {31'd0, out_valid}, 32'd0);
    force_en = 1'b0;
    in_valid = 4'b0000;
    tick();

    // Randomised traffic through the scoreboard.
    for (int i = 0; i < 300; i++) begin
      in_data = $urandom;
      in_valid = 4'($urandom_range(0, 15));
      force_en = ($urandom_range(0, 3) == 0);
      force_sel = 2'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid = 4'b0000;
    force_en = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();

    // Fixed priority: ch1 always beats ch3.
    fp_in_valid = 4'b1010;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("fp_in_ready", {28'd0, fp_in_ready}, 32'b0010);
      check_eq("fp_sel", {30'd0, fp_out_sel}, 32'd1);
      check_eq("fp_data", {24'd0, fp_out_data}, 32'hA1);
    end
    fp_in_valid = 4'b0000;

    // Three channels: out-of-range force gives nothing, then wrap 2 -> 0.
    c3_force_en = 1'b1;
    c3_force_sel = 2'd3;
    c3_in_valid = 3'b111;
    for (int i = 0; i < 2; i++) begin
      tick();
      check_eq("c3_force_ready", {29'd0, c3_in_ready}, 32'd0);
      check_eq("c3_force_valid", {31'd0, c3_out_valid}, 32'd0);
    end
    c3_force_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("c3_rr_sel", {30'd0, c3_out_sel}, i % 3);
      check_eq("c3_rr_data", {24'd0, c3_out_data}, 32'hC0 + (i % 3));
    end
    c3_in_valid = 3'b000;

    // Asynchronous reset while a word is held; ptr is 3 before the pulse.
    in_data = 32'h13121110;
    in_valid = 4'b0100;
    out_ready = 1'b0;
    tick();
    check_eq("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_valid", {31'd0, out_valid}, 32'd0);
    check_eq("async_rst_data", {24'd0, out_data}, 32'd0);
    check_eq("async_rst_sel", {30'd0, out_sel}, 32'd0);
    check_eq("async_rst_ready", {28'd0, in_ready}, 32'd0);
    #1;
    rst_n = 1'b1;
    q.delete();
    m_ptr = 0;
    in_valid = 4'b1100;
    out_ready = 1'b1;
    tick();
    check_eq("post_rst_sel", {30'd0, out_sel}, 32'd2);
    in_valid = 4'b0000;
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
